mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single `memory` read/write port between the instruction-fetch unit (IF, read-only) and the load/store unit (LS, read or write).
- Sits between the core's front end / LSU and the `memory` instance.
- Drives `memory`'s write_mem, funct3, write_address, write_data and read_address, and routes its registered read_data back to the requester that owns it.
- Enforces `memory`'s timing rule: read_address must be held through the response cycle, because the RAM/peripheral select is combinational on read_address.

Parameters:
- STARVE_LIMIT, 4: number of consecutive cycles IF may be refused before it gets priority over LS. Legal range 1..15.
- CNT_W, 4: width of the starvation counter. Must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- if_req_valid  in  1  IF read request
- if_req_addr  in  32  IF byte address (word aligned)
- if_req_ready  out  1  IF request accepted this cycle
- if_rsp_valid  out  1  IF read data valid
- if_rsp_data  out  32  IF read data
- ls_req_valid  in  1  LS request
- ls_req_write  in  1  1 = store, 0 = load
- ls_req_funct3  in  3  RV32I load/store funct3
- ls_req_addr  in  32  LS byte address
- ls_req_wdata  in  32  store data
- ls_req_ready  out  1  LS request accepted this cycle
- ls_rsp_valid  out  1  LS load data valid (never asserted for stores)
- ls_rsp_data  out  32  LS load data
- mem_write_mem  out  1  to memory write_mem
- mem_funct3  out  3  to memory funct3
- mem_write_address  out  32  to memory write_address
- mem_write_data  out  32  to memory write_data
- mem_read_address  out  32  to memory read_address
- mem_read_data  in  32  from memory read_data

Behaviour:
- Clock and reset: single clock clk. reset is asynchronous and active-high.
- Reset values: state = IDLE, starve_cnt = 0, rd_addr_q = 0, owner_q = IF, both *_rsp_valid = 0, mem_write_mem = 0, mem_funct3 = 3'b010, mem_read_address = 0.
- Transactions: at most one accepted per cycle, across both requesters. A request is accepted when valid && ready in the same cycle. Ready is combinational from valid, state and starve_cnt.
- Grant priority: LS wins by default. IF wins when starve_cnt >= STARVE_LIMIT.
- starve_cnt: +1 (saturating) each cycle if_req_valid is high and IF is not granted. Cleared on IF grant, or when if_req_valid is low.
- Write grant (LS store):
  - mem_write_mem = 1 for that cycle only; mem_funct3 = ls_req_funct3; write_address/data = request.
  - No response is returned.
  - mem_read_address stays at rd_addr_q.
- Read grant:
  - mem_read_address = request address, registered into rd_addr_q.
  - mem_funct3 = 3'b010 for IF, ls_req_funct3 for LS.
  - owner_q is registered; state goes to RESP.
- Latency: response exactly 1 cycle after a read grant. The owner's rsp_valid = 1 and rsp_data = mem_read_data. The other requester's rsp_valid = 0.
- Responses are not backpressured; requesters must accept them.
- States:
  - IDLE -> RESP on a read grant. Stays IDLE on a write grant or no grant.
  - RESP -> RESP on a new read grant, allowed only if region(new addr) == region(rd_addr_q), where region = (addr[31:13] == 0).
  - RESP -> IDLE otherwise.
- During RESP:
  - mem_read_address is driven from rd_addr_q, except when a same-region read is granted that cycle.
  - A different-region read is refused (ready = 0) that cycle.
  - A write may be granted during RESP; mem_funct3 follows the write, which is safe because memory latches the read format on the previous edge.
- When idle: mem_write_mem = 0, mem_funct3 = 3'b010, mem_read_address = rd_addr_q.
- Simultaneous requests: exactly one ready is high. The loser's ready = 0 and it must hold its request stable.
- Reset during RESP: the pending response is dropped (no rsp_valid) and the FSM returns to IDLE.
- Same-address read-after-write on consecutive cycles returns the new data. The arbiter adds no forwarding.

Decomposition:
- Package mem_arb_pkg holds:
  - typedef enum logic [0:0] {IDLE, RESP} arb_state_t
  - typedef enum logic {OWN_IF, OWN_LS} owner_t
  - localparam FETCH_FUNCT3 = 3'b010
  - localparam RAM_TOP_BITS = 19 (addr[31:13])
- One sub-module, arb_grant: combinational priority / region-check grant logic plus the starvation counter register. The FSM and muxing live in the top module.

Test Plan:
- IF read 0x00000010 alone, memory word = 0x12345678 -> if_req_ready = 1 at cycle 0; if_rsp_valid = 1 and if_rsp_data = 0x12345678 at cycle 1; ls_rsp_valid stays 0.
- IF read and LS lw 0x00000020 both valid, starve_cnt = 0 -> LS granted, IF ready = 0; ls_rsp_valid one cycle later; IF granted the next cycle.
- LS valid every cycle, IF valid continuously, STARVE_LIMIT = 4 -> IF refused exactly 4 cycles, granted on the 5th; starve_cnt returns to 0.
- LS sb 0xFFFFFFFF, wdata 0x80 -> mem_write_mem = 1, mem_funct3 = 000 for one cycle; no rsp_valid. A following LS lbu 0xFFFFFFFF returns 0x00000080.
- RAM read at 0x100 granted, then next-cycle LS lw 0xFFFFFFF8 -> ls_req_ready = 0 in RESP; mem_read_address held at 0x100; IF response correct; LS granted the cycle after.
- reset asserted asynchronously mid-cycle during RESP -> outputs go to reset values immediately; no rsp_valid after reset deasserts.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
// It also holds the address-region helpers. The memory's RAM/peripheral select
// is a combinational decode of read_address, so the arbiter must know which
// region an address falls in.
package mem_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RESP = 1'b1
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

  // Instruction fetch always reads a full word.
  localparam logic [2:0] FETCH_FUNCT3 = 3'b010;

  // An address is in RAM when addr[31:13] is all zeros.
  localparam int RAM_TOP_BITS = 19;

  // True when the address decodes to the RAM region.
  function automatic logic is_ram(input logic [31:0] addr);
    return (addr[31 -: RAM_TOP_BITS] == {RAM_TOP_BITS{1'b0}});
  endfunction

  // True when two addresses select the same memory region.
  function automatic logic same_region(input logic [31:0] addr_a,
                                       input logic [31:0] addr_b);
    return (is_ram(addr_a) == is_ram(addr_b));
  endfunction

endpackage

// File: rtl/arb_grant.sv
// Grant logic for the memory port arbiter.
// It picks at most one requester per cycle. LS wins by default. IF wins once
// it has been refused STARVE_LIMIT cycles in a row.
// While a read response is pending, any new read must target the same region
// as the held read address. Writes are always eligible.
module arb_grant
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_if_valid,
  input  logic [31:0] i_if_addr,
  input  logic        i_ls_valid,
  input  logic        i_ls_write,
  input  logic [31:0] i_ls_addr,
  input  logic        i_in_resp,
  input  logic [31:0] i_rd_addr,
  output logic        o_if_grant,
  output logic        o_ls_grant
);

  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] MAX_C   = {CNT_W{1'b1}};

  logic [CNT_W-1:0] r_starve_cnt;
  logic             w_if_ok;
  logic             w_ls_ok;
  logic             w_if_starved;

  // Decide eligibility, then priority. Nothing is granted while reset is high,
  // so the memory-side outputs hold their reset values during reset.
  always_comb begin
    w_if_ok      = 1'b0;
    w_ls_ok      = 1'b0;
    w_if_starved = 1'b0;
    o_if_grant   = 1'b0;
    o_ls_grant   = 1'b0;
    if (reset) begin
      w_if_ok = 1'b0;
      w_ls_ok = 1'b0;
    end else begin
      w_if_ok = i_if_valid && (!i_in_resp || same_region(i_if_addr, i_rd_addr));
      w_ls_ok = i_ls_valid &&
                (i_ls_write || !i_in_resp || same_region(i_ls_addr, i_rd_addr));
    end
    w_if_starved = (r_starve_cnt >= LIMIT_C);
    if (w_if_ok && w_if_starved) begin
      o_if_grant = 1'b1;
    end else if (w_ls_ok) begin
      o_ls_grant = 1'b1;
    end else if (w_if_ok) begin
      o_if_grant = 1'b1;
    end else begin
      o_if_grant = 1'b0;
      o_ls_grant = 1'b0;
    end
  end

  // Count consecutive cycles IF waited without a grant. Saturate at the maximum.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_starve_cnt <= {CNT_W{1'b0}};
    end else if (i_if_valid && !o_if_grant) begin
      if (r_starve_cnt != MAX_C) begin
        r_starve_cnt <= r_starve_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      r_starve_cnt <= {CNT_W{1'b0}};
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory read/write port between instruction fetch (IF,
// read-only) and the load/store unit (LS).
// Read data comes back exactly one cycle after a read grant. In that response
// cycle, read_address is held from the registered copy. The memory's region
// select is combinational on read_address, so it must not move unless a new
// read in the same region is granted.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req_valid,
  input  logic [31:0] if_req_addr,
  output logic        if_req_ready,
  output logic        if_rsp_valid,
  output logic [31:0] if_rsp_data,
  input  logic        ls_req_valid,
  input  logic        ls_req_write,
  input  logic [2:0]  ls_req_funct3,
  input  logic [31:0] ls_req_addr,
  input  logic [31:0] ls_req_wdata,
  output logic        ls_req_ready,
  output logic        ls_rsp_valid,
  output logic [31:0] ls_rsp_data,
  output logic        mem_write_mem,
  output logic [2:0]  mem_funct3,
  output logic [31:0] mem_write_address,
  output logic [31:0] mem_write_data,
  output logic [31:0] mem_read_address,
  input  logic [31:0] mem_read_data
);

  arb_state_t  r_state;
  owner_t      r_owner;
  logic [31:0] r_rd_addr;

  logic w_if_grant;
  logic w_ls_grant;
  logic w_ls_wr;
  logic w_ls_rd;
  logic w_rd_grant;
  logic w_in_resp;

  assign w_in_resp  = (r_state == RESP);
  assign w_ls_wr    = w_ls_grant && ls_req_write;
  assign w_ls_rd    = w_ls_grant && !ls_req_write;
  assign w_rd_grant = w_if_grant || w_ls_rd;

  assign if_req_ready = w_if_grant;
  assign ls_req_ready = w_ls_grant;

  arb_grant #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) u_grant (
    .clk        (clk),
    .reset      (reset),
    .i_if_valid (if_req_valid),
    .i_if_addr  (if_req_addr),
    .i_ls_valid (ls_req_valid),
    .i_ls_write (ls_req_write),
    .i_ls_addr  (ls_req_addr),
    .i_in_resp  (w_in_resp),
    .i_rd_addr  (r_rd_addr),
    .o_if_grant (w_if_grant),
    .o_ls_grant (w_ls_grant)
  );

  // Drive the memory port from the granted request. When nothing is granted,
  // hold the last read address and the word format.
  always_comb begin
    mem_write_mem     = 1'b0;
    mem_funct3        = FETCH_FUNCT3;
    mem_write_address = 32'h0000_0000;
    mem_write_data    = 32'h0000_0000;
    mem_read_address  = r_rd_addr;
    if (w_if_grant) begin
      mem_funct3       = FETCH_FUNCT3;
      mem_read_address = if_req_addr;
    end else if (w_ls_wr) begin
      mem_write_mem     = 1'b1;
      mem_funct3        = ls_req_funct3;
      mem_write_address = ls_req_addr;
      mem_write_data    = ls_req_wdata;
    end else if (w_ls_rd) begin
      mem_funct3       = ls_req_funct3;
      mem_read_address = ls_req_addr;
    end else begin
      mem_write_mem    = 1'b0;
      mem_read_address = r_rd_addr;
    end
  end

  // Route the memory's registered read data to whichever requester owns the
  // pending read.
  always_comb begin
    if_rsp_valid = 1'b0;
    ls_rsp_valid = 1'b0;
    if_rsp_data  = mem_read_data;
    ls_rsp_data  = mem_read_data;
    if (w_in_resp) begin
      if_rsp_valid = (r_owner == OWN_IF);
      ls_rsp_valid = (r_owner == OWN_LS);
    end else begin
      if_rsp_valid = 1'b0;
      ls_rsp_valid = 1'b0;
    end
  end

  // Track the pending read: its state, its owner and the address to hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_owner   <= OWN_IF;
      r_rd_addr <= 32'h0000_0000;
    end else if (w_rd_grant) begin
      r_state   <= RESP;
      r_owner   <= w_if_grant ? OWN_IF : OWN_LS;
      r_rd_addr <= mem_read_address;
    end else begin
      r_state <= IDLE;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small behavioural memory.
// Expected read responses go into a scoreboard queue when a read is issued.
// A monitor pops and compares each response the DUT presents.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req_valid;
  logic [31:0] if_req_addr;
  logic        if_req_ready;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_data;
  logic        ls_req_valid;
  logic        ls_req_write;
  logic [2:0]  ls_req_funct3;
  logic [31:0] ls_req_addr;
  logic [31:0] ls_req_wdata;
  logic        ls_req_ready;
  logic        ls_rsp_valid;
  logic [31:0] ls_rsp_data;
  logic        mem_write_mem;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_write_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_address;
  logic [31:0] mem_read_data;

  typedef struct packed {
    logic        own_ls;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_LIMIT(4), .CNT_W(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .if_req_valid      (if_req_valid),
    .if_req_addr       (if_req_addr),
    .if_req_ready      (if_req_ready),
    .if_rsp_valid      (if_rsp_valid),
    .if_rsp_data       (if_rsp_data),
    .ls_req_valid      (ls_req_valid),
    .ls_req_write      (ls_req_write),
    .ls_req_funct3     (ls_req_funct3),
    .ls_req_addr       (ls_req_addr),
    .ls_req_wdata      (ls_req_wdata),
    .ls_req_ready      (ls_req_ready),
    .ls_rsp_valid      (ls_rsp_valid),
    .ls_rsp_data       (ls_rsp_data),
    .mem_write_mem     (mem_write_mem),
    .mem_funct3        (mem_funct3),
    .mem_write_address (mem_write_address),
    .mem_write_data    (mem_write_data),
    .mem_read_address  (mem_read_address),
    .mem_read_data     (mem_read_data)
  );

  // ---------------- behavioural memory ----------------
  logic [7:0] init_mem [0:1023];
  logic [7:0] wr_mem   [0:1023];
  logic       wr_vld   [0:1023];

  function automatic logic [9:0] midx(input logic [31:0] a);
    return {a[31], a[8:0]};
  endfunction

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    logic [9:0] i;
    i = midx(a);
    return wr_vld[i] ? wr_mem[i] : init_mem[i];
  endfunction

  function automatic logic [31:0] load_fmt(input logic [31:0] a, input logic [2:0] f3);
    logic [7:0]  b0;
    logic [15:0] h0;
    b0 = rd_byte(a);
    h0 = {rd_byte(a + 32'd1), b0};
    case (f3)
      3'b000:  return {{24{b0[7]}}, b0};
      3'b001:  return {{16{h0[15]}}, h0};
      3'b100:  return {24'd0, b0};
      3'b101:  return {16'd0, h0};
      default: return {rd_byte(a + 32'd3), rd_byte(a + 32'd2), h0};
    endcase
  endfunction

  // Memory: stores on the edge, registered read data formatted by funct3.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 1024; i++) wr_vld[i] <= 1'b0;
    end else if (mem_write_mem) begin
      for (int k = 0; k < 4; k++) begin
        if (k == 0 || (k == 1 && mem_funct3[1:0] != 2'b00) || mem_funct3[1:0] == 2'b10) begin
          wr_mem[midx(mem_write_address + 32'(k))] <= mem_write_data[8*k +: 8];
          wr_vld[midx(mem_write_address + 32'(k))] <= 1'b1;
        end
      end
    end
    mem_read_data <= load_fmt(mem_read_address, mem_funct3);
  end

  task automatic preload_word(input logic [31:0] a, input logic [31:0] w);
    for (int k = 0; k < 4; k++) init_mem[midx(a + 32'(k))] = w[8*k +: 8];
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic own_ls, input logic [31:0] d);
    sb_q.push_back({own_ls, d});
  endtask

  // Monitor: every presented response must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && (if_rsp_valid || ls_rsp_valid)) begin
      chk("rsp_one_hot", {31'd0, if_rsp_valid && ls_rsp_valid}, 32'd0);
      chk("rsp_expected", {31'd0, sb_q.size() != 0}, 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("rsp_owner", {31'd0, ls_rsp_valid}, {31'd0, e.own_ls});
        chk("rsp_data", ls_rsp_valid ? ls_rsp_data : if_rsp_data, e.data);
      end
    end
  end

  task automatic idle_inputs();
    if_req_valid  = 1'b0;
    if_req_addr   = 32'd0;
    ls_req_valid  = 1'b0;
    ls_req_write  = 1'b0;
    ls_req_funct3 = 3'b010;
    ls_req_addr   = 32'd0;
    ls_req_wdata  = 32'd0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic ls_set(input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d);
    ls_req_valid  = 1'b1;
    ls_req_write  = wr;
    ls_req_funct3 = f3;
    ls_req_addr   = a;
    ls_req_wdata  = d;
  endtask

  // Bound on total run time.
  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, time %0t limit 200000", $time);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 1024; i++) init_mem[i] = 8'h00;
    preload_word(32'h0000_0010, 32'h1234_5678);
    preload_word(32'h0000_0020, 32'hCAFE_F00D);
    preload_word(32'h0000_0040, 32'h1111_1111);
    preload_word(32'h0000_0100, 32'hA5A5_0100);
    preload_word(32'hFFFF_FFF8, 32'h0BAD_BEEF);
    preload_word(32'hFFFF_FFFC, 32'h5A00_0000);
    idle_inputs();

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_write_mem", {31'd0, mem_write_mem}, 32'd0);
    chk("rst_funct3", {29'd0, mem_funct3}, 32'd2);
    chk("rst_read_addr", mem_read_address, 32'd0);
    chk("rst_if_rsp_valid", {31'd0, if_rsp_valid}, 32'd0);
    chk("rst_ls_rsp_valid", {31'd0, ls_rsp_valid}, 32'd0);
    next_cycle();
    reset = 1'b0;

    // IF read alone
    if_req_valid = 1'b1; if_req_addr = 32'h0000_0010;
    @(negedge clk);
    chk("t1_if_ready", {31'd0, if_req_ready}, 32'd1);
    chk("t1_ls_ready", {31'd0, ls_req_ready}, 32'd0);
    chk("t1_rd_addr", mem_read_address, 32'h0000_0010);
    chk("t1_funct3", {29'd0, mem_funct3}, 32'd2);
    push_exp(1'b0, 32'h1234_5678);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    chk("t1_if_rsp_valid", {31'd0, if_rsp_valid}, 32'd1);
    chk("t1_ls_rsp_valid", {31'd0, ls_rsp_valid}, 32'd0);
    next_cycle();

    // Simultaneous IF and LS lw: LS first, IF next
    if_req_valid = 1'b1; if_req_addr = 32'h0000_0010;
    ls_set(1'b0, 3'b010, 32'h0000_0020, 32'd0);
    @(negedge clk);
    chk("t2_ls_ready", {31'd0, ls_req_ready}, 32'd1);
    chk("t2_if_ready", {31'd0, if_req_ready}, 32'd0);
    push_exp(1'b1, 32'hCAFE_F00D);
    next_cycle();
    ls_req_valid = 1'b0;
    @(negedge clk);
    chk("t2_ls_rsp_valid", {31'd0, ls_rsp_valid}, 32'd1);
    chk("t2_if_ready_next", {31'd0, if_req_ready}, 32'd1);
    push_exp(1'b0, 32'h1234_5678);
    next_cycle();
    idle_inputs();
    next_cycle();

    // Starvation: IF refused 4 cycles, granted on the 5th, then counter cleared
    if_req_valid = 1'b1; if_req_addr = 32'h0000_0010;
    ls_set(1'b0, 3'b010, 32'h0000_0020, 32'd0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 4) begin
        chk("t3_if_ready_granted", {31'd0, if_req_ready}, 32'd1);
        chk("t3_ls_ready_refused", {31'd0, ls_req_ready}, 32'd0);
        push_exp(1'b0, 32'h1234_5678);
      end else begin
        chk("t3_if_ready_refused", {31'd0, if_req_ready}, 32'd0);
        chk("t3_ls_ready_granted", {31'd0, ls_req_ready}, 32'd1);
        push_exp(1'b1, 32'hCAFE_F00D);
      end
      next_cycle();
    end
    idle_inputs();
    next_cycle();

    // Byte store to peripheral space, then lbu of the same byte
    ls_set(1'b1, 3'b000, 32'hFFFF_FFFF, 32'h0000_0080);
    @(negedge clk);
    chk("t4_sb_ready", {31'd0, ls_req_ready}, 32'd1);
    chk("t4_sb_write_mem", {31'd0, mem_write_mem}, 32'd1);
    chk("t4_sb_funct3", {29'd0, mem_funct3}, 32'd0);
    chk("t4_sb_waddr", mem_write_address, 32'hFFFF_FFFF);
    chk("t4_sb_wdata", mem_write_data, 32'h0000_0080);
    next_cycle();
    ls_set(1'b0, 3'b100, 32'hFFFF_FFFF, 32'd0);
    @(negedge clk);
    chk("t4_lbu_write_mem", {31'd0, mem_write_mem}, 32'd0);
    chk("t4_lbu_ready", {31'd0, ls_req_ready}, 32'd1);
    chk("t4_lbu_funct3", {29'd0, mem_funct3}, 32'd4);
    chk("t4_lbu_raddr", mem_read_address, 32'hFFFF_FFFF);
    push_exp(1'b1, 32'h0000_0080);
    next_cycle();
    idle_inputs();
    next_cycle();

    // RAM store then load back, then back-to-back same-region lh
    ls_set(1'b1, 3'b010, 32'h0000_0040, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("t7_sw_ready", {31'd0, ls_req_ready}, 32'd1);
    next_cycle();
    ls_set(1'b0, 3'b010, 32'h0000_0040, 32'd0);
    @(negedge clk);
    push_exp(1'b1, 32'hDEAD_BEEF);
    next_cycle();
    ls_set(1'b0, 3'b001, 32'h0000_0022, 32'd0);
    @(negedge clk);
    chk("t7_lh_ready_in_resp", {31'd0, ls_req_ready}, 32'd1);
    push_exp(1'b1, 32'hFFFF_CAFE);
    next_cycle();
    idle_inputs();
    next_cycle();

    // RAM read, then a peripheral read is held off for the response cycle
    if_req_valid = 1'b1; if_req_addr = 32'h0000_0100;
    @(negedge clk);
    chk("t5_if_ready", {31'd0, if_req_ready}, 32'd1);
    push_exp(1'b0, 32'hA5A5_0100);
    next_cycle();
    if_req_valid = 1'b0;
    ls_set(1'b0, 3'b010, 32'hFFFF_FFF8, 32'd0);
    @(negedge clk);
    chk("t5_ls_ready_region", {31'd0, ls_req_ready}, 32'd0);
    chk("t5_rd_addr_held", mem_read_address, 32'h0000_0100);
    next_cycle();
    @(negedge clk);
    chk("t5_ls_ready_after", {31'd0, ls_req_ready}, 32'd1);
    chk("t5_rd_addr_periph", mem_read_address, 32'hFFFF_FFF8);
    push_exp(1'b1, 32'h0BAD_BEEF);
    next_cycle();
    idle_inputs();
    next_cycle();

    // Reset mid-cycle during RESP drops the pending response
    if_req_valid = 1'b1; if_req_addr = 32'h0000_0010;
    @(negedge clk);
    chk("t6_if_ready", {31'd0, if_req_ready}, 32'd1);
    @(posedge clk);
    #2;
    idle_inputs();
    reset = 1'b1;
    #1;
    chk("t6_if_rsp_valid", {31'd0, if_rsp_valid}, 32'd0);
    chk("t6_rd_addr", mem_read_address, 32'd0);
    chk("t6_funct3", {29'd0, mem_funct3}, 32'd2);
    chk("t6_write_mem", {31'd0, mem_write_mem}, 32'd0);
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    chk("t6_no_rsp_after", {31'd0, if_rsp_valid || ls_rsp_valid}, 32'd0);
    repeat (2) next_cycle();
    @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
